// File: rtl/micro_pkg.sv
// Shared definitions for the product-to-BCD display slice: FSM encodings,
// 7-segment patterns and the double-dabble step.
package micro_pkg;

  localparam int PROD_W     = 8;
  localparam int BCD_DIGITS = 3;
  localparam int WORK_W     = BCD_DIGITS * 4 + PROD_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] a;
    a = {add3(w[19:16]), add3(w[15:12]), add3(w[11:8]), w[7:0]};
    return {a[WORK_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high {g,f,e,d,c,b,a} pattern, with blanking.
module seg7_decode
  import micro_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/product_bcd_display.sv
// Accepts an 8-bit product, converts it to three BCD digits by sequential
// double-dabble, and scans the held result onto a multiplexed 7-seg display.
//
// state | meaning
// IDLE  | waiting for a product, in_ready high
// SHIFT | one add-3/shift step per cycle, 8 cycles
// DONE  | result just loaded into bcd, out_valid high
module product_bcd_display
  import micro_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int BLANK_LZ = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    in_valid,
  input  logic [PROD_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [BCD_DIGITS*4-1:0] bcd,
  output logic [6:0]              seg,
  output logic [2:0]              dig_sel
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  logic [1:0]        state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_next;
  logic [2:0]        cnt;
  logic [15:0]       presc;
  logic [3:0]        nib_sel;
  logic              blank_sel;
  logic [6:0]        seg_dec;

  assign in_ready  = (state == IDLE);
  assign work_next = dabble_step(work);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= {{(BCD_DIGITS*4){1'b0}}, in_data};
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt + 3'd1;
          // Final shift: publish the digits on the same edge that enters DONE.
          if (cnt == 3'd7) begin
            bcd       <= work_next[WORK_W-1:PROD_W];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc   <= '0;
      dig_sel <= 3'b001;
    end else if (presc == PRESC_MAX) begin
      presc   <= '0;
      dig_sel <= {dig_sel[1:0], dig_sel[2]};
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_comb begin
    nib_sel   = bcd[3:0];
    blank_sel = 1'b0;
    case (dig_sel)
      3'b010: begin
        nib_sel   = bcd[7:4];
        blank_sel = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      3'b100: begin
        nib_sel   = bcd[11:8];
        blank_sel = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0);
      end
      default: begin
        nib_sel   = bcd[3:0];
        blank_sel = 1'b0;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble (nib_sel),
    .blank  (blank_sel),
    .seg    (seg_dec)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) seg <= SEG_0;
    else         seg <= seg_dec;
  end

endmodule
